// File: rtl/fpga_reg_cmd_master.sv
// Avalon-MM command master for the four-register FPGA slave.
// Buffers valid/ready commands in a 2-deep FIFO and issues one single-beat access per command.
module fpga_reg_cmd_master #(
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_address,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_data,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  address;
    logic [31:0] data;
  } cmd_t;

  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY);

  state_t     state;
  cmd_t       fifo_mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] fifo_count;
  logic       push;
  logic       pop;
  cmd_t       head;
  logic [1:0] lat_cnt;

  assign cmd_ready = (fifo_count != 2'd2);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (fifo_count != 2'd0);
  assign head      = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= '{write: cmd_write, address: cmd_address, data: cmd_data};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Reads hold chipselect for LAT_LAST+1 cycles; lat_cnt counts the extra ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      lat_cnt        <= '0;
      rsp_valid      <= 1'b0;
      rsp_write      <= 1'b0;
      rsp_data       <= '0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      wr_count       <= '0;
      rd_count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            avm_address    <= head.address;
            avm_writedata  <= head.data;
            rsp_write      <= head.write;
            avm_chipselect <= 1'b1;
            avm_write_n    <= ~head.write;
            lat_cnt        <= '0;
            state          <= BUS;
          end
        end
        BUS: begin
          if (!avm_write_n) begin
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            rsp_data       <= avm_writedata;
            wr_count       <= wr_count + 16'd1;
            rsp_valid      <= 1'b1;
            state          <= RESP;
          end else if (lat_cnt == LAT_LAST) begin
            avm_chipselect <= 1'b0;
            rsp_data       <= avm_readdata;
            rd_count       <= rd_count + 16'd1;
            rsp_valid      <= 1'b1;
            state          <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
